// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for mem_port_arbiter: FSM state encoding,
// requester ids and the wait-counter width rule.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_WAIT   = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic ARB_ID_IF = 1'b0;
  localparam logic ARB_ID_D  = 1'b1;

  // Wait counter must be able to hold MEM_LAT-1.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way pick between IF (bit 0) and D (bit 1); one-hot grant.
// Ties are round-robin unless MEM_ARB_DATA_PRIO_EN makes D always win.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

`ifdef MEM_ARB_DATA_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
`ifdef MEM_ARB_DATA_PRIO_EN
        o_grant = 2'b10;
`else
        // The port that did not win last time gets the tie.
        o_grant = (i_last_grant == ARB_ID_D) ? 2'b01 : 2'b10;
`endif
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one registered-read memory between fetch (IF) and load/store (D) ports
// through an IDLE->ACCESS->WAIT->DONE sequence. Option macro: MEM_ARB_DATA_PRIO_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  // Handshake: a requester holds req (level) and its operands until its
  // one-cycle valid pulse; operands are captured at grant, so later changes
  // are ignored, and req still high after valid is taken as a new request.

  localparam int CNT_W = cnt_width(MEM_LAT);

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  arb_state_t        r_state, w_next_state;
  logic              r_grant_id;
  logic              r_last_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
  logic              r_if_valid, r_d_valid;
  logic [1:0]        w_grant;
  logic              w_any_req;
  logic              w_wait_done;

  arb_rr2 u_arb (
    .i_req        ({d_req, if_req}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_any_req   = if_req | d_req;
  assign w_wait_done = (r_state == ARB_WAIT) && (r_cnt == CNT_W'(MEM_LAT - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ARB_IDLE:   if (w_any_req) w_next_state = ARB_ACCESS;
      ARB_ACCESS: w_next_state = ARB_WAIT;
      ARB_WAIT:   if (w_wait_done) w_next_state = ARB_DONE;
      ARB_DONE:   w_next_state = ARB_IDLE;
      default:    w_next_state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_grant_id   <= ARB_ID_IF;
      r_last_grant <= ARB_ID_D;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_valid   <= 1'b0;
      r_d_valid    <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_grant_id   <= w_grant[1];
            r_last_grant <= w_grant[1];
            if (w_grant[1]) begin
              r_we    <= d_we;
              r_addr  <= d_addr;
              r_wdata <= d_wdata;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= if_addr;
              r_wdata <= '0;
            end
          end
        end
        ARB_ACCESS: r_cnt <= '0;
        ARB_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_wait_done) begin
            // Stores complete with a valid but leave the read data untouched.
            if (r_grant_id == ARB_ID_D) begin
              r_d_valid <= 1'b1;
              if (!r_we) r_d_rdata <= mem_rdata;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en      = (r_state == ARB_ACCESS);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign if_rdata    = r_if_rdata;
  assign if_valid    = r_if_valid;
  assign d_rdata     = r_d_rdata;
  assign d_valid     = r_d_valid;
  assign busy        = (r_state != ARB_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand sequences for reset, operand capture, contention and MEM_LAT=3.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT with MEM_LAT=1
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, d_valid, mem_en, mem_we, busy;
  logic [1:0]  dbg_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .o_dbg_state(dbg_state)
  );

  // DUT with MEM_LAT=3
  logic        if3_req, d3_req, d3_we;
  logic [31:0] if3_addr, d3_addr, d3_wdata;
  logic [31:0] if3_rdata, d3_rdata, mem3_addr, mem3_wdata, mem3_rdata;
  logic        if3_valid, d3_valid, mem3_en, mem3_we, busy3;
  logic [1:0]  dbg3_state;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if3_req), .if_addr(if3_addr), .if_rdata(if3_rdata), .if_valid(if3_valid),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_rdata(d3_rdata), .d_valid(d3_valid),
    .mem_en(mem3_en), .mem_we(mem3_we), .mem_addr(mem3_addr), .mem_wdata(mem3_wdata),
    .mem_rdata(mem3_rdata), .busy(busy3), .o_dbg_state(dbg3_state)
  );

  // Memory models: read data is correct only in the cycle MEM_LAT after mem_en.
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (rst) begin
      mem1[4]  <= 32'hDEADBEEF;
      mem1[5]  <= 32'hCAFEF00D;
      mem1[8]  <= 32'h11112222;
      mem1[17] <= 32'h33334444;
    end else if (mem_en && mem_we) begin
      mem1[mem_addr[9:2]] <= mem_wdata;
    end
    mem_rdata <= (mem_en && !mem_we) ? mem1[mem_addr[9:2]] : 32'hBAD00001;
  end

  always @(posedge clk) begin
    if (rst) mem3[4] <= 32'hDEADBEEF;
    else if (mem3_en && mem3_we) mem3[mem3_addr[9:2]] <= mem3_wdata;
    p3[0] <= (mem3_en && !mem3_we) ? mem3[mem3_addr[9:2]] : 32'hBAD00003;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem3_rdata = p3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  logic exp_winner_d;
  int   en_count;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Transaction table: winner port, op, address, store data, expected rdata.
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 32'h00000000};
    vecs[2] = '{1'b1, 1'b0, 32'h40, 32'h0,        32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 32'h14, 32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'h14, 32'hA5A5A5A5, 32'hCAFEF00D};

    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = 32'h0;
    if3_req = 1'b0; if3_addr = 32'h0; d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h10; d3_wdata = 32'h0;

    // Reset with both requests high
    step();
    step();
    chk("rst state", dbg_state, 2'd0);
    chk("rst busy", busy, 1'b0);
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst mem_we", mem_we, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst valids", {if_valid, d_valid}, 2'b00);
    chk("rst rdata", {if_rdata, d_rdata}, 64'h0);
    chk("rst busy3", busy3, 1'b0);
    if_req = 1'b0; d_req = 1'b0; d3_req = 1'b0;
    rst = 1'b0;

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].is_d) begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end else begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end
      chk($sformatf("v%0d idle busy", i), busy, 1'b0);
      step();
      chk($sformatf("v%0d access mem_en", i), mem_en, 1'b1);
      chk($sformatf("v%0d access mem_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d access mem_we", i), mem_we, vecs[i].we);
      if (vecs[i].we) chk($sformatf("v%0d access mem_wdata", i), mem_wdata, vecs[i].wdata);
      step();
      chk($sformatf("v%0d wait mem_en", i), mem_en, 1'b0);
      chk($sformatf("v%0d wait valids", i), {if_valid, d_valid}, 2'b00);
      step();
      chk($sformatf("v%0d done valids", i), {if_valid, d_valid},
          vecs[i].is_d ? 2'b01 : 2'b10);
      chk($sformatf("v%0d done busy", i), busy, 1'b1);
      if (vecs[i].is_d) chk($sformatf("v%0d d_rdata", i), d_rdata, vecs[i].exp_rdata);
      else chk($sformatf("v%0d if_rdata", i), if_rdata, vecs[i].exp_rdata);
      if_req = 1'b0; d_req = 1'b0;
      step();
      chk($sformatf("v%0d back idle", i), {busy, if_valid, d_valid}, 3'b000);
    end

    // Operands captured at grant; later changes and a dropped req are ignored
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    step();
    d_req = 1'b0; d_addr = 32'h14; d_we = 1'b1;
    chk("capture mem_addr", mem_addr, 32'h10);
    chk("capture mem_we", mem_we, 1'b0);
    step();
    step();
    chk("capture d_valid", d_valid, 1'b1);
    chk("capture d_rdata", d_rdata, 32'hDEADBEEF);
    step();
    chk("capture no new req", busy, 1'b0);
    d_we = 1'b0;

    // Reset during WAIT aborts silently
    if_req = 1'b1; if_addr = 32'h10;
    step();
    step();
    chk("midrst in wait", dbg_state, 2'd2);
    rst = 1'b1; if_req = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst state", dbg_state, 2'd0);
    chk("midrst busy", busy, 1'b0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("midrst no valid c%0d", c), {if_valid, d_valid}, 2'b00);
      step();
    end

    // Contention: both held for four transactions
    if_req = 1'b1; if_addr = 32'h20;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_DATA_PRIO_EN
      exp_winner_d = 1'b1;
`else
      exp_winner_d = (t % 2 == 1);
`endif
      step();
      chk($sformatf("tie%0d mem_addr", t), mem_addr, exp_winner_d ? 32'h44 : 32'h20);
      step();
      step();
      chk($sformatf("tie%0d valids", t), {if_valid, d_valid}, exp_winner_d ? 2'b01 : 2'b10);
      chk($sformatf("tie%0d rdata", t), exp_winner_d ? d_rdata : if_rdata,
          exp_winner_d ? 32'h33334444 : 32'h11112222);
      if (t == 3) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      step();
    end
    chk("tie end idle", busy, 1'b0);

    // MEM_LAT=3: lone load, valid in cycle 5, single mem_en cycle
    d3_req = 1'b1; d3_we = 1'b0; d3_addr = 32'h10;
    en_count = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (mem3_en) en_count++;
      if (c < 5) chk($sformatf("lat3 c%0d valid", c), {if3_valid, d3_valid}, 2'b00);
    end
    chk("lat3 d_valid", d3_valid, 1'b1);
    chk("lat3 d_rdata", d3_rdata, 32'hDEADBEEF);
    d3_req = 1'b0;
    step();
    if (mem3_en) en_count++;
    chk("lat3 mem_en cycles", en_count, 1);
    chk("lat3 idle", {busy3, d3_valid}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
